// File: rtl/fifo_arb_pkg.sv
// Shared types, constants and the round-robin pick helper for the FIFO push arbiter.
// Latency: none, declarations and pure functions only.
// Backpressure: not applicable.
package fifo_arb_pkg;

  // Default build configuration; the top recomputes its own full level from BIT_DEPTH
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_BIT_DEPTH = 4;
  localparam int FULL          = (1 << DEF_BIT_DEPTH) - 1;

  // Widest supported producer count; the helper works on a padded vector
  localparam int MAX_REQ = 8;

  typedef logic [DEF_WIDTH-1:0] word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Index of the first set bit at or after rr, wrapping modulo n (n in 2..MAX_REQ)
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         rr,
                                         input int                 n);
    logic [2:0] idx;
    logic       found;
    int         j;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = (int'(rr) + k) % n;
      if (k < n && !found && req[j[2:0]]) begin
        idx   = j[2:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_picker.sv
// Round-robin priority encoder: first requester at or after base, with a valid flag.
// Latency: purely combinational.
// Backpressure: none, the caller decides whether the pick is used.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   base_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  logic [MAX_REQ-1:0] req_pad;
  logic [2:0]         pick;

  assign req_pad = MAX_REQ'(req_i);
  assign pick    = rr_pick(req_pad, 3'(base_i), NUM_REQ);
  assign idx_o   = IDX_W'(pick);
  assign vld_o   = |req_i;

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter with bounded bursts and an occupancy-gated pop for a 2**BIT_DEPTH fifo.
// Latency: accept edge to registered push is 1 cycle; pop is combinational from pop_req.
// Backpressure: no grant while occ==FULL (same-cycle pops not credited); pop only when a committed word exists.
// Optional: define FIFO_ARB_LEVEL_CHECK_EN to add the sticky level_err cross-check against full/empty.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int BIT_DEPTH = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     push,
  output logic [WIDTH-1:0]         data_in,
  input  logic                     pop_req,
  output logic                     pop,
  input  logic                     full,
  input  logic                     empty,
  output logic [BIT_DEPTH-1:0]     level
`ifdef FIFO_ARB_LEVEL_CHECK_EN
  ,
  output logic                     level_err
`endif
);

  localparam int                   IDX_W     = $clog2(NUM_REQ);
  localparam logic [BIT_DEPTH-1:0] FULL_LVL  = BIT_DEPTH'((1 << BIT_DEPTH) - 1);
  localparam logic [3:0]           BURST_MAX = 4'(MAX_BURST);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_REQ - 1);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [3:0]           bcnt_q,  bcnt_d;
  logic [IDX_W-1:0]     rr_q,    rr_d;
  logic [BIT_DEPTH-1:0] occ_q,   occ_d;
  logic                 push_q;
  logic [WIDTH-1:0]     data_q;

  logic [IDX_W-1:0]     pick_base;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic                 acc;
  logic [IDX_W-1:0]     win;
  logic [BIT_DEPTH-1:0] cnt_c;
  logic [WIDTH-1:0]     words [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign words[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  // A finished burst rotates priority to just past its owner before re-arbitrating
  assign pick_base = (state_q == BURST) ? next_idx(owner_q) : rr_q;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i  (req),
    .base_i (pick_base),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  // Words actually stored in the fifo: the one in the push register is not there yet
  assign cnt_c = occ_q - BIT_DEPTH'(push_q);
  assign pop   = pop_req && (cnt_c != '0);
  assign occ_d = occ_q + BIT_DEPTH'(acc) - BIT_DEPTH'(pop);
  assign level = occ_q;
  assign push  = push_q;
  assign data_in = data_q;

  // Next-state and grant decision; at FULL everything holds and nothing is granted
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    bcnt_d  = bcnt_q;
    rr_d    = rr_q;
    acc     = 1'b0;
    win     = owner_q;
    if (occ_q != FULL_LVL) begin
      if (state_q == BURST && req[owner_q] && bcnt_q < BURST_MAX) begin
        acc    = 1'b1;
        win    = owner_q;
        bcnt_d = bcnt_q + 4'd1;
      end else begin
        if (state_q == BURST) begin
          rr_d    = next_idx(owner_q);
          state_d = IDLE;
        end
        if (pick_vld) begin
          acc     = 1'b1;
          win     = pick_idx;
          owner_d = pick_idx;
          bcnt_d  = 4'd1;
          if (MAX_BURST > 1) begin
            state_d = BURST;
          end else begin
            rr_d = next_idx(pick_idx);
          end
        end
      end
    end
  end

  // One-hot accept strobe, forced quiet while reset is asserted
  always_comb begin
    gnt = '0;
    if (acc && reset_n) begin
      gnt[win] = 1'b1;
    end
  end

  // Arbitration state, occupancy and the registered fifo write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      bcnt_q  <= '0;
      rr_q    <= '0;
      occ_q   <= '0;
      push_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      bcnt_q  <= bcnt_d;
      rr_q    <= rr_d;
      occ_q   <= occ_d;
      push_q  <= acc;
      if (acc) begin
        data_q <= words[win];
      end
    end
  end

`ifdef FIFO_ARB_LEVEL_CHECK_EN
  logic level_err_q;
  logic level_mism;

  assign level_mism = (empty != (cnt_c == '0)) || (full != (cnt_c == FULL_LVL));
  assign level_err  = level_err_q;

  // Sticky record of any disagreement between our committed count and the fifo flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_err_q <= 1'b0;
    end else begin
      level_err_q <= level_err_q | level_mism;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = full ^ empty;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: directed scenarios plus randomized traffic vs. a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_push_arbiter;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int BD    = 4;
  localparam int MB    = 4;
  localparam int FULLV = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b1;

  // DUT with MAX_BURST=4
  logic [N-1:0]   req4, gnt4;
  logic [N*W-1:0] data4;
  logic           push4, pop_req4, pop4, full4, empty4, lerr4;
  logic [W-1:0]   din4;
  logic [BD-1:0]  level4;

  // DUT with MAX_BURST=1
  logic [N-1:0]   req1, gnt1;
  logic [N*W-1:0] data1;
  logic           push1, pop_req1, pop1, full1, empty1, lerr1;
  logic [W-1:0]   din1;
  logic [BD-1:0]  level1;

  int checks = 0;
  int errors = 0;

  fifo_push_arbiter #(.NUM_REQ(N), .WIDTH(W), .BIT_DEPTH(BD), .MAX_BURST(MB)) dut4 (
    .clk(clk), .reset_n(reset_n), .req(req4), .req_data(data4), .gnt(gnt4),
    .push(push4), .data_in(din4), .pop_req(pop_req4), .pop(pop4),
    .full(full4), .empty(empty4), .level(level4)
`ifdef FIFO_ARB_LEVEL_CHECK_EN
    , .level_err(lerr4)
`endif
  );

  fifo_push_arbiter #(.NUM_REQ(N), .WIDTH(W), .BIT_DEPTH(BD), .MAX_BURST(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req1), .req_data(data1), .gnt(gnt1),
    .push(push1), .data_in(din1), .pop_req(pop_req1), .pop(pop1),
    .full(full1), .empty(empty1), .level(level1)
`ifdef FIFO_ARB_LEVEL_CHECK_EN
    , .level_err(lerr1)
`endif
  );

`ifndef FIFO_ARB_LEVEL_CHECK_EN
  assign lerr4 = 1'b0;
  assign lerr1 = 1'b0;
`endif

  // ---------------- reference model of dut4 ----------------
  int          m_occ, m_pushq, m_owner, m_bcnt, m_rr;
  bit          m_burst;
  logic [W-1:0] m_data;

  function automatic logic [N-1:0] onehot(input int w);
    if (w < 0) return '0;
    return N'(1 << w);
  endfunction

  // Who should be accepted this cycle, or -1
  function automatic int exp_win(input logic [N-1:0] rq);
    int base, idx;
    if (m_occ == FULLV) return -1;
    if (m_burst && rq[m_owner[1:0]] && m_bcnt < MB) return m_owner;
    base = m_burst ? (m_owner + 1) % N : m_rr;
    for (int k = 0; k < N; k++) begin
      idx = (base + k) % N;
      if (rq[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // Expected {gnt, pop, push, level, data_in}
  function automatic logic [41:0] exp_vec();
    int w;
    w = exp_win(req4);
    return {onehot(w), logic'(pop_req4 && (m_occ - m_pushq) > 0),
            logic'(m_pushq != 0), 4'(m_occ), m_data};
  endfunction

  task automatic mdl_init();
    m_occ = 0; m_pushq = 0; m_owner = 0; m_bcnt = 0; m_rr = 0; m_burst = 0; m_data = '0;
  endtask

  task automatic mdl_adv(input logic [N-1:0] rq, input logic prq, input logic [N*W-1:0] rd);
    int w;
    bit cont, popd;
    w    = exp_win(rq);
    cont = m_burst && (w == m_owner) && rq[m_owner[1:0]] && (m_bcnt < MB);
    popd = prq && (m_occ - m_pushq) > 0;
    if (w >= 0) m_data = rd[w*W +: W];
    if (cont) begin
      m_bcnt++;
    end else if (m_occ != FULLV) begin
      if (m_burst) begin
        m_rr = (m_owner + 1) % N;
        if (w < 0) m_burst = 0;
      end
      if (w >= 0) begin
        m_owner = w;
        m_bcnt  = 1;
        if (MB > 1) m_burst = 1;
        else        m_rr = (w + 1) % N;
      end
    end
    m_occ   = m_occ + ((w >= 0) ? 1 : 0) - (popd ? 1 : 0);
    m_pushq = (w >= 0) ? 1 : 0;
  endtask

  // Advance one clock for dut4 and keep the fifo flags consistent with the model
  task automatic adv4(output int w);
    w = exp_win(req4);
    mdl_adv(req4, pop_req4, data4);
    @(posedge clk);
    #1;
    empty4 = ((m_occ - m_pushq) == 0);
    full4  = ((m_occ - m_pushq) == FULLV);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    req4     = '0;
    pop_req4 = 1'b0;
    req1     = '0;
    pop_req1 = 1'b0;
    empty4   = 1'b1;
    full4    = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mdl_init();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [41:0] got;
    reset_n  = 1'b1;
    req4     = '1;
    data4    = {$urandom, $urandom, $urandom, $urandom};
    pop_req4 = 1'b1;
    empty4   = 1'b1;
    full4    = 1'b0;
    req1     = '1;
    data1    = '0;
    pop_req1 = 1'b0;
    empty1   = 1'b1;
    full1    = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    got = {gnt4, pop4, push4, level4, din4};
    checks++;
    if (got !== 42'd0) begin
      errors++;
      $display("FAIL reset_dut4 got=%h exp=%h", got, 42'd0);
    end
    checks++;
    if ({gnt1, pop1, push1, level1} !== 7'd0) begin
      errors++;
      $display("FAIL reset_dut1 got=%b exp=%b", {gnt1, pop1, push1, level1}, 7'd0);
    end
    checks++;
    if ({lerr4, lerr1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_level_err got=%b exp=00", {lerr4, lerr1});
    end
  endtask

  task automatic test_rotation();
    int prev;
    logic [W-1:0] wd;
    do_reset();
    for (int i = 0; i < N; i++) data1[i*W +: W] = 32'hD00D_0000 + i;
    req1 = '1;
    prev = -1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c < 5) begin
        checks++;
        if (gnt1 !== onehot(c % N)) begin
          errors++;
          $display("FAIL rotation_gnt c=%0d got=%b exp=%b", c, gnt1, onehot(c % N));
        end
      end
      if (prev >= 0) begin
        wd = data1[prev*W +: W];
        checks++;
        if ({push1, din1} !== {1'b1, wd}) begin
          errors++;
          $display("FAIL rotation_push c=%0d got=%b/%h exp=1/%h", c, push1, din1, wd);
        end
      end
      prev = c % N;
      @(posedge clk);
      #1;
      if (c == 4) req1 = '0;
    end
  endtask

  task automatic test_burst_cap();
    logic [41:0] got, ex;
    int w;
    do_reset();
    req4  = 4'b0011;
    data4 = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      got = {gnt4, pop4, push4, level4, din4};
      ex  = exp_vec();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL burst_model c=%0d got=%h exp=%h", c, got, ex);
      end
      if (c <= 4) begin
        checks++;
        if (gnt4 !== ((c < 4) ? 4'b0001 : 4'b0010)) begin
          errors++;
          $display("FAIL burst_cap c=%0d got=%b exp=%b", c, gnt4, (c < 4) ? 4'b0001 : 4'b0010);
        end
      end
      adv4(w);
      if (w >= 0) data4[w*W +: W] = $urandom;
    end
    req4 = '0;
  endtask

  task automatic test_fill();
    logic [41:0] got, ex;
    int w;
    do_reset();
    req4  = '1;
    data4 = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 19; c++) begin
      pop_req4 = (c == 16);
      @(negedge clk);
      got = {gnt4, pop4, push4, level4, din4};
      ex  = exp_vec();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL fill_model c=%0d got=%h exp=%h", c, got, ex);
      end
      if (c == 15 || c == 18) begin
        checks++;
        if ({gnt4, level4} !== {4'b0000, 4'd15}) begin
          errors++;
          $display("FAIL fill_full c=%0d got gnt=%b level=%0d exp gnt=0000 level=15", c, gnt4, level4);
        end
      end
      if (c == 16) begin
        checks++;
        if ({pop4, gnt4} !== {1'b1, 4'b0000}) begin
          errors++;
          $display("FAIL fill_pop got pop=%b gnt=%b exp pop=1 gnt=0000", pop4, gnt4);
        end
      end
      if (c == 17) begin
        checks++;
        if (gnt4 == 4'b0000 || $isunknown(gnt4)) begin
          errors++;
          $display("FAIL fill_reaccept got gnt=%b exp nonzero", gnt4);
        end
      end
      adv4(w);
      if (w >= 0) data4[w*W +: W] = $urandom;
    end
    req4     = '0;
    pop_req4 = 1'b0;
  endtask

  task automatic test_empty_gate();
    logic [41:0] got, ex;
    int w;
    do_reset();
    req4     = 4'b0001;
    data4    = {$urandom, $urandom, $urandom, $urandom};
    pop_req4 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      got = {gnt4, pop4, push4, level4, din4};
      ex  = exp_vec();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL empty_model c=%0d got=%h exp=%h", c, got, ex);
      end
      checks++;
      if (pop4 !== (c == 2)) begin
        errors++;
        $display("FAIL empty_gate c=%0d got pop=%b exp=%b", c, pop4, (c == 2));
      end
      adv4(w);
      req4 = '0;
    end
    pop_req4 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [41:0] got, ex;
    int w;
    do_reset();
    req4  = 4'b0110;
    data4 = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      got = {gnt4, pop4, push4, level4, din4};
      ex  = exp_vec();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL resetmid_model c=%0d got=%h exp=%h", c, got, ex);
      end
      adv4(w);
      if (w >= 0) data4[w*W +: W] = $urandom;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({push4, level4, gnt4} !== 9'd0) begin
      errors++;
      $display("FAIL resetmid_async got push=%b level=%0d gnt=%b exp 0/0/0000", push4, level4, gnt4);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mdl_init();
    empty4 = 1'b1;
    full4  = 1'b0;
    req4   = '1;
    @(negedge clk);
    got = {gnt4, pop4, push4, level4, din4};
    ex  = exp_vec();
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL resetmid_restart_model got=%h exp=%h", got, ex);
    end
    checks++;
    if (gnt4 !== 4'b0001) begin
      errors++;
      $display("FAIL resetmid_restart got gnt=%b exp=0001", gnt4);
    end
    adv4(w);
    req4 = '0;
  endtask

  task automatic test_random();
    logic [41:0] got, ex;
    int w;
    int pct [4] = '{20, 80, 35, 60};
    do_reset();
    data4 = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req4[i] && $urandom_range(0, 1) == 1) begin
          req4[i]         = 1'b1;
          data4[i*W +: W] = $urandom;
        end
      end
      pop_req4 = ($urandom_range(0, 99) < pct[(c / 150) % 4]);
      @(negedge clk);
      got = {gnt4, pop4, push4, level4, din4};
      ex  = exp_vec();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL random c=%0d got=%h exp=%h", c, got, ex);
      end
      checks++;
      if (lerr4 !== 1'b0) begin
        errors++;
        $display("FAIL random_level_err c=%0d got=%b exp=0", c, lerr4);
      end
      adv4(w);
      if (w >= 0) begin
        if ($urandom_range(0, 1) == 1) req4[w] = 1'b0;
        else data4[w*W +: W] = $urandom;
      end
    end
    req4     = '0;
    pop_req4 = 1'b0;
  endtask

`ifdef FIFO_ARB_LEVEL_CHECK_EN
  task automatic test_level_err();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c == 1) empty4 = 1'b0;
      if (c == 2) empty4 = 1'b1;
      @(negedge clk);
      checks++;
      if (lerr4 !== (c >= 2)) begin
        errors++;
        $display("FAIL level_err c=%0d got=%b exp=%b", c, lerr4, (c >= 2));
      end
      @(posedge clk);
      #1;
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (lerr4 !== 1'b0) begin
      errors++;
      $display("FAIL level_err_cleared got=%b exp=0", lerr4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rotation();
    test_burst_cap();
    test_fill();
    test_empty_gate();
    test_reset_mid();
    test_random();
`ifdef FIFO_ARB_LEVEL_CHECK_EN
    test_level_err();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
